// File: rtl/ram_master_ctrl.sv
// Initiator-side controller for a synchronous RAM with a csn/rwn port.
// Single-beat writes, wrapping read bursts, one-cycle registered-read latency absorbed.
//
// state | meaning
// IDLE  | ready for a request, RAM deselected
// WRITE | write cycle presented to RAM, commits on the next edge
// READ  | one read address issued per cycle, beat counter counts down
// DRAIN | last read address sampled, waiting for the final beat
module ram_master_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_csn,
  output logic              ram_rwn,
  input  logic [DATA_W-1:0] ram_dataout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                inflight_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_datain_q;
  logic                ram_csn_q;
  logic                ram_rwn_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_last_q;
  logic                wr_done_q;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ram_addr   = ram_addr_q;
  assign ram_datain = ram_datain_q;
  assign ram_csn    = ram_csn_q;
  assign ram_rwn    = ram_rwn_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_last   = rsp_last_q;
  assign wr_done    = wr_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_datain_q <= '0;
      ram_csn_q    <= 1'b1;
      ram_rwn_q    <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_last_q   <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      // The RAM returns data one cycle after it samples a read, so the
      // beat pipeline trails the READ state by exactly one edge.
      inflight_q  <= (state_q == READ);
      rsp_valid_q <= inflight_q;
      rsp_last_q  <= inflight_q && (state_q == DRAIN);
      if (inflight_q) rsp_data_q <= ram_dataout;
      wr_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ram_addr_q <= req_addr;
            ram_csn_q  <= 1'b0;
            if (req_write) begin
              ram_datain_q <= req_wdata;
              ram_rwn_q    <= 1'b0;
              state_q      <= WRITE;
            end else begin
              ram_rwn_q <= 1'b1;
              cnt_q     <= req_len;
              state_q   <= READ;
            end
          end
        end
        WRITE: begin
          ram_csn_q <= 1'b1;
          ram_rwn_q <= 1'b1;
          wr_done_q <= 1'b1;
          state_q   <= IDLE;
        end
        READ: begin
          if (cnt_q != '0) begin
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
            cnt_q      <= cnt_q - ADDR_W'(1);
          end else begin
            ram_csn_q <= 1'b1;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
        end
        default: begin
          ram_csn_q <= 1'b1;
          ram_rwn_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule
